dm_responder: RTL
=================

// Module: dm_responder
// PURPOSE
//  Data-memory responder for the pipelined core's external M-stage port (m_data_addr/wdata/byteen, m_inst_addr).
//  Serves same-cycle word reads and byte-enabled writes from a word array.
//  Records every accepted store as a trace entry {pc, addr, data, byteen} in a FIFO with a valid/ready drain port.
//  Sits between the core top level and the testbench/trace checker.
// PARAMETERS
//  ADDR_W     12            word-address bits; memory holds 2**ADDR_W words (4096 words = 16 KiB)
//  BASE_ADDR  32'h0000_0000 byte address of word 0; must be 4-byte aligned
//  LOG_AW     3             log FIFO address bits; depth = 2**LOG_AW entries
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   synchronous, active-low reset
//  m_data_addr    in   32  byte address from core M stage
//  m_data_wdata   in   32  store data, already lane-shifted by the core
//  m_data_byteen  in   4   byte enables; 4'b0000 = no store this cycle
//  m_inst_addr    in   32  PC of the M-stage instruction
//  m_data_rdata   out  32  word at m_data_addr; combinational
//  log_valid      out  1   FIFO head holds an entry
//  log_ready      in   1   consumer pops head when log_valid && log_ready
//  log_pc         out  32  head entry: store PC
//  log_addr       out  32  head entry: word-aligned byte address
//  log_data       out  32  head entry: store data (see CONFIGURATION)
//  log_byteen     out  4   head entry: byte enables
//  log_count      out  LOG_AW+1  number of entries held
//  log_overflow   out  1   sticky: at least one entry dropped
//  err_oob        out  1   registered pulse, 1 cycle: the previous cycle accessed an address outside the memory
// BEHAVIOUR
//  - Index: off = m_data_addr - BASE_ADDR. In range iff off < 4*2**ADDR_W. Word index = off[ADDR_W+1:2]. addr[1:0] is ignored.
//  - Read: m_data_rdata = mem[idx] when in range, else 0. Purely combinational, zero latency.
//  - A read and a write to the same word in the same cycle returns the pre-write value.
//  - Write: at the edge with reset==1, byteen!=0 and in range: for each i with byteen[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]. Other bytes are kept.
//  - Log push happens on the same edge as the write. Entry = {m_inst_addr, BASE_ADDR+4*idx, data, byteen}.
//  - Out of range: no memory update and no log push. err_oob=1 on the following cycle, and only for the cycle after an out-of-range access.
//    Out-of-range reads with byteen=0 raise err_oob as well.
//  - FIFO: a pop occurs when log_valid&&log_ready. Head outputs are registered from FIFO storage; no combinational path from log_ready.
//  - FIFO full: push with a simultaneous pop is accepted and count stays at 2**LOG_AW.
//    Push without a pop is dropped: entry discarded, log_overflow<=1, memory is still written.
//  - FIFO empty: pop is ignored; log_valid=0; head fields read 0.
//  - Read/write pointers wrap modulo 2**LOG_AW. log_count = pushes - pops, saturating at 0 and at 2**LOG_AW.
//  - Reset (reset==0 at an edge), including mid-drain or mid-store:
//    * all memory words <= 0
//    * FIFO emptied: pointers and count = 0, log_valid=0
//    * log_overflow=0, err_oob=0
//    * the store presented in that cycle is discarded
//  - Reset values: log_valid 0, log_pc/addr/data/byteen 0, log_count 0, log_overflow 0, err_oob 0.
//    m_data_rdata follows mem, so it reads 0 after reset.
// CONFIGURATION
//  DM_RESP_LOG_MERGED_EN
//    defined: log_data = full word after the merge; bytes not enabled show the old memory content.
//    undefined: log_data = raw m_data_wdata; bytes not enabled carry the core's don't-care lanes.
//  Memory behaviour is identical in both builds.
// STRUCTURE
//  Shared package dm_resp_pkg holds:
//    - DM_RESP_LOG_W = 100 (32+32+32+4)
//    - typedef dm_resp_log_t packed {pc, addr, data, byteen}
//    - the in-range/index helper function
//  Sub-module dm_resp_log_fifo: synchronous FIFO parameterised by width and LOG_AW, with push/pop/full/empty/count/overflow.
//  The top level holds the memory array, the byte merge, the range check and the err_oob register.
// TESTING
//  1 Reset then read 0x0000_0010 -> rdata=0, log_valid=0, log_count=0, log_overflow=0.
//  2 sw: addr 0x10, wdata 0xDEADBEEF, be 4'hF, pc 0x3000, log_ready=0 -> next cycle rdata@0x10=0xDEADBEEF, log_valid=1, log_pc=0x3000, log_addr=0x10, log_byteen=4'hF, log_count=1.
//  3 sb: preload 0x11223344@0x20, write addr 0x22, wdata 0x00AB0000, be 4'b0100
//      -> mem 0x11AB3344; log_data 0x11AB3344 with DM_RESP_LOG_MERGED_EN, 0x00AB0000 without.
//  4 Fill with 8 stores and log_ready=0, then issue a 9th store:
//      - count stays 8, log_overflow=1, memory still updated
//      - 10th store with log_ready=1 is accepted; count stays 8
//      - drained order matches push order 1..8 then 10.
//  5 Store to 0x0000_4000 (out of range at ADDR_W=12) -> memory unchanged, no push, err_oob=1 for exactly one cycle, rdata=0.
//  6 Drive reset=0 for one edge while FIFO holds 3 entries and a store is presented
//      -> count=0, log_valid=0, log_overflow=0, word read 0, store not applied.

Source files
------------

// File: rtl/dm_resp_pkg.sv
// Shared types and address helpers for the data-memory responder and its store-trace FIFO.
package dm_resp_pkg;

    localparam int DM_RESP_LOG_W = 100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } dm_resp_log_t;

    // The limit is computed one bit wider so a 30-bit word space does not wrap to zero.
    function automatic logic dm_resp_in_range(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int unsigned aw);
        logic [31:0] off;
        logic [32:0] lim;
        off = addr - base;
        lim = 33'd4 << aw;
        return {1'b0, off} < lim;
    endfunction

    function automatic logic [31:0] dm_resp_word_off(input logic [31:0] addr,
                                                     input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    function automatic logic [31:0] dm_resp_merge(input logic [31:0] old_word,
                                                  input logic [31:0] wdata,
                                                  input logic [3:0]  byteen);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_resp_if.sv
// M-stage data port plus store-trace drain port between the core side and the responder.
interface dm_resp_if #(parameter int LOG_AW = 3);

    logic [31:0]     m_data_addr;
    logic [31:0]     m_data_wdata;
    logic [3:0]      m_data_byteen;
    logic [31:0]     m_inst_addr;
    logic [31:0]     m_data_rdata;
    logic            log_valid;
    logic            log_ready;
    logic [31:0]     log_pc;
    logic [31:0]     log_addr;
    logic [31:0]     log_data;
    logic [3:0]      log_byteen;
    logic [LOG_AW:0] log_count;
    logic            log_overflow;
    logic            err_oob;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, log_ready,
        input  m_data_rdata, log_valid, log_pc, log_addr, log_data, log_byteen,
               log_count, log_overflow, err_oob
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, log_ready,
        output m_data_rdata, log_valid, log_pc, log_addr, log_data, log_byteen,
               log_count, log_overflow, err_oob
    );

endinterface

// File: rtl/dm_resp_log_fifo.sv
// Synchronous store-trace FIFO; the head entry is held in a register so the outputs
// never depend combinationally on pop_i.
module dm_resp_log_fifo #(
    parameter int W      = 100,
    parameter int LOG_AW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic [W-1:0]    push_data_i,
    input  logic            pop_i,
    output logic [W-1:0]    head_o,
    output logic            empty_o,
    output logic [LOG_AW:0] count_o,
    output logic            overflow_o
);

    localparam int DEPTH = 1 << LOG_AW;
    localparam logic [LOG_AW:0] FULL_CNT = {1'b1, {LOG_AW{1'b0}}};

    logic [W-1:0]      store_q [DEPTH];
    logic [LOG_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_AW:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [W-1:0]      head_q, head_d;
    logic              full, empty, pop_ok, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        head_d   = '0;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push_i && full && !pop_ok) ovf_d = 1'b1;
        // A single remaining entry that was pushed this edge is not in storage yet.
        if (count_d == '0)
            head_d = '0;
        else if (push_ok && count_d == {{LOG_AW{1'b0}}, 1'b1})
            head_d = push_data_i;
        else
            head_d = store_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_ok) store_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o     = head_q;
    assign empty_o    = empty;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: combinational word reads, byte-enabled writes, store-trace FIFO.
// Build option DM_RESP_LOG_MERGED_EN logs the post-merge word instead of raw store data.
module dm_responder
    import dm_resp_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LOG_AW    = 3
) (
    input  logic     clk,
    input  logic     reset,
    dm_resp_if.slave bus
);

    localparam int MEM_WORDS = 1 << ADDR_W;

    logic [31:0]       mem_q [MEM_WORDS];
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       old_word, merged_word;
    logic              wr_en;
    logic              err_oob_q, err_oob_d;
    logic              fifo_empty;
    dm_resp_log_t      entry, head;

    assign in_range    = dm_resp_in_range(bus.m_data_addr, BASE_ADDR, ADDR_W);
    assign idx         = ADDR_W'(dm_resp_word_off(bus.m_data_addr, BASE_ADDR));
    assign old_word    = mem_q[idx];
    assign merged_word = dm_resp_merge(old_word, bus.m_data_wdata, bus.m_data_byteen);
    assign wr_en       = in_range && (bus.m_data_byteen != 4'b0000);
    assign err_oob_d   = !in_range;

    // Read returns the pre-write word since mem_q only changes at the edge.
    assign bus.m_data_rdata = in_range ? old_word : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx] <= merged_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) err_oob_q <= 1'b0;
        else        err_oob_q <= err_oob_d;
    end

    always_comb begin
        entry        = '0;
        entry.pc     = bus.m_inst_addr;
        entry.addr   = BASE_ADDR + {{(30-ADDR_W){1'b0}}, idx, 2'b00};
`ifdef DM_RESP_LOG_MERGED_EN
        entry.data   = merged_word;
`else
        entry.data   = bus.m_data_wdata;
`endif
        entry.byteen = bus.m_data_byteen;
    end

    dm_resp_log_fifo #(
        .W      (DM_RESP_LOG_W),
        .LOG_AW (LOG_AW)
    ) u_log_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (wr_en),
        .push_data_i (entry),
        .pop_i       (bus.log_ready),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (bus.log_count),
        .overflow_o  (bus.log_overflow)
    );

    assign bus.log_valid  = !fifo_empty;
    assign bus.log_pc     = head.pc;
    assign bus.log_addr   = head.addr;
    assign bus.log_data   = head.data;
    assign bus.log_byteen = head.byteen;
    assign bus.err_oob    = err_oob_q;

endmodule
